// File: rtl/io_bus_responder.sv
// CPU-facing IO responder: LED register, debounced button/switch mailbox,
// scanned 8-digit hex display value and a free-running cycle counter.
module io_bus_responder #(
    parameter int DEBOUNCE = 1000000,
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  io_addr,
    input  logic [31:0] io_dout,
    input  logic        io_we,
    output logic [31:0] io_din,
    input  logic [7:0]  sw,
    input  logic        btn,
    output logic [7:0]  led,
    output logic [2:0]  seg_sel,
    output logic [3:0]  seg_hex
);

    localparam int DB_W   = $clog2(DEBOUNCE + 1);
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    localparam logic [7:0] ADDR_LED   = 8'h00;
    localparam logic [7:0] ADDR_ACK   = 8'h04;
    localparam logic [7:0] ADDR_IN    = 8'h08;
    localparam logic [7:0] ADDR_SEG   = 8'h0C;
    localparam logic [7:0] ADDR_CYCLE = 8'h10;

    function automatic logic [3:0] nibble_sel(input logic [31:0] value, input logic [2:0] idx);
        logic [3:0] nib;
        nib = 4'h0;
        for (int i = 0; i < 8; i++) begin
            if (idx == 3'(i)) begin
                nib = value[4*i +: 4];
            end else begin
                nib = nib;
            end
        end
        return nib;
    endfunction

    logic [7:0]        r_led;
    logic [31:0]       r_seg;
    logic [31:0]       r_cyc_cnt;
    logic              r_in_vld;
    logic [7:0]        r_in_data;
    logic              r_btn_s1;
    logic              r_btn_s2;
    logic [7:0]        r_sw_s1;
    logic [7:0]        r_sw_s2;
    logic [DB_W-1:0]   r_db_cnt;
    logic              r_btn_db;
    logic              r_btn_db_d;
    logic [SCAN_W-1:0] r_scan_div;
    logic [2:0]        r_seg_sel;

    logic w_led_wr;
    logic w_seg_wr;
    logic w_ack_wr;
    logic w_press;

    assign w_led_wr = io_we && (io_addr == ADDR_LED);
    assign w_seg_wr = io_we && (io_addr == ADDR_SEG);
    assign w_ack_wr = io_we && (io_addr == ADDR_ACK);
    assign w_press  = r_btn_db && !r_btn_db_d;

    // CPU-writable registers and the cycle counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_led     <= 8'h00;
            r_seg     <= 32'h0000_0000;
            r_cyc_cnt <= 32'h0000_0000;
        end else begin
            r_cyc_cnt <= r_cyc_cnt + 32'h0000_0001;
            if (w_led_wr) begin
                r_led <= io_dout[7:0];
            end
            if (w_seg_wr) begin
                r_seg <= io_dout;
            end
        end
    end

    // Two-stage synchronizers for the asynchronous board inputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_btn_s1 <= 1'b0;
            r_btn_s2 <= 1'b0;
            r_sw_s1  <= 8'h00;
            r_sw_s2  <= 8'h00;
        end else begin
            r_btn_s1 <= btn;
            r_btn_s2 <= r_btn_s1;
            r_sw_s1  <= sw;
            r_sw_s2  <= r_sw_s1;
        end
    end

    // Debounce: the new level must hold DEBOUNCE cycles; any bounce back restarts the count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_db_cnt   <= '0;
            r_btn_db   <= 1'b0;
            r_btn_db_d <= 1'b0;
        end else begin
            r_btn_db_d <= r_btn_db;
            if (r_btn_s2 != r_btn_db) begin
                if (r_db_cnt == DB_LAST) begin
                    r_btn_db <= r_btn_s2;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + DB_W'(1);
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    // Input mailbox; a press coinciding with an ACK write wins over the clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_vld  <= 1'b0;
            r_in_data <= 8'h00;
        end else begin
            if (w_press && (!r_in_vld || w_ack_wr)) begin
                r_in_vld  <= 1'b1;
                r_in_data <= r_sw_s2;
            end else if (w_ack_wr) begin
                r_in_vld <= 1'b0;
            end
        end
    end

    // Display scan: advance the digit index each time the divider wraps
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scan_div <= '0;
            r_seg_sel  <= 3'd0;
        end else begin
            if (r_scan_div == SCAN_LAST) begin
                r_scan_div <= '0;
                r_seg_sel  <= r_seg_sel + 3'd1;
            end else begin
                r_scan_div <= r_scan_div + SCAN_W'(1);
            end
        end
    end

    // Read mux, combinational on the address
    always_comb begin
        io_din = 32'h0000_0000;
        case (io_addr)
            ADDR_LED:   io_din = {24'h00_0000, r_led};
            ADDR_ACK:   io_din = {31'h0000_0000, r_in_vld};
            ADDR_IN:    io_din = {24'h00_0000, r_in_data};
            ADDR_SEG:   io_din = r_seg;
            ADDR_CYCLE: io_din = r_cyc_cnt;
            default:    io_din = 32'h0000_0000;
        endcase
    end

    assign led     = r_led;
    assign seg_sel = r_seg_sel;
    assign seg_hex = nibble_sel(r_seg, r_seg_sel);

endmodule

// File: doc/io_bus_responder.md
Name: io_bus_responder

Overview:
- Peripheral-side responder for the CPU's memory-mapped IO port (io_addr/io_dout/io_we out of the CPU, io_din into it).
- Decodes CPU IO accesses and provides:
  - an LED output register;
  - a debounced switch/button input mailbox with a valid/acknowledge handshake;
  - a 32-bit hex value shown on a scanned 8-digit 7-segment display;
  - a free-running cycle counter.
- Sits between the CPU top and the board pins.

Parameters:
DEBOUNCE, 1000000, consecutive stable cycles required before the synchronized button level is accepted (>=1)
SCAN_DIV, 100000, clock cycles per 7-segment digit slot (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
io_addr  input  8  IO address from CPU
io_dout  input  32  IO write data from CPU
io_we  input  1  IO write enable from CPU
io_din  output  32  IO read data to CPU (combinational on io_addr)
sw  input  8  board switches (asynchronous)
btn  input  1  board push button (asynchronous, active-high)
led  output  8  LED register
seg_sel  output  3  active digit index 0..7
seg_hex  output  4  hex nibble for active digit

Behaviour:
- Address map:
  - 0x00 W: LED, led <= io_dout[7:0]. R: {24'b0, led}.
  - 0x04 W: ACK, any write clears in_vld. R: {31'b0, in_vld}.
  - 0x08 R: IN_DATA, {24'b0, in_data}. Writes ignored.
  - 0x0C W: SEG, seg_reg <= io_dout. R: seg_reg.
  - 0x10 R: CYCLE, cyc_cnt. Writes ignored.
  - Any other address: reads return 0, writes ignored.
- Writes take effect on the clk edge where io_we=1. io_din is purely combinational; a read after a write sees the new value from the next cycle.
- Reset (rst=0, asynchronous): led=0, seg_reg=0, in_vld=0, in_data=0, cyc_cnt=0, seg_sel=0, scan divider=0, synchronizers=0, debounce counter=0, btn_db=0. seg_hex therefore reads 0 during reset.
- Input path:
  - btn and sw each pass through a 2-FF synchronizer.
  - Debounce: while the synchronized btn differs from btn_db, a counter increments. When it reaches DEBOUNCE, btn_db takes the new level and the counter clears. Any bounce back to the btn_db level clears the counter.
  - A btn_db rising edge gives a one-cycle press pulse.
  - On the press pulse with in_vld=0: in_data <= synchronized sw, in_vld <= 1.
  - On the press pulse with in_vld=1: the press is dropped; in_data is unchanged and no overrun is recorded.
  - Press pulse and ACK write in the same cycle: the press wins, so in_vld=1 and in_data = new sw.
  - Latency from a clean btn rise to in_vld=1 is 2 + DEBOUNCE + 1 cycles. A button release never sets anything.
- Display:
  - Divider counts 0..SCAN_DIV-1. On wrap, seg_sel increments modulo 8 (7 -> 0).
  - seg_hex = seg_reg[4*seg_sel+3 : 4*seg_sel], combinational on registered seg_sel and seg_reg.
  - A SEG write updates the shown nibble immediately and does not reset the scan.
- cyc_cnt increments every cycle and wraps 0xFFFFFFFF -> 0.
- A reset asserted mid-debounce or mid-scan aborts it; nothing is retained.

Test Plan:
(Bench uses DEBOUNCE=4, SCAN_DIV=2.)
- LED/SEG write: write 0x00 <- 0x1A5, then 0x0C <- 0x89ABCDEF -> led=0xA5; reads of 0x00 and 0x0C return 0xA5 and 0x89ABCDEF. seg_hex steps F,E,D,C,B,A,9,8 as seg_sel goes 0..7, changing every 2 cycles, then wraps to 0.
- Handshake: sw=0x3C, btn held high -> in_vld=1 exactly 7 cycles after the rise; read 0x08 = 0x3C. Write 0x04 -> read 0x04 = 0.
- Bounce and overrun:
  - btn high 3 cycles, low 1, high 3 -> no press.
  - With in_vld=1, a second press with sw=0x55 -> in_data stays 0x3C.
- Collision: align the ACK write with the press-pulse cycle (sw=0x77) -> in_vld stays 1, in_data=0x77.
- Decode and counter:
  - Read 0x14 or 0xFF -> 0; write 0x08 has no effect.
  - cyc_cnt delta between two reads N cycles apart equals N.
  - Force cyc_cnt near 0xFFFFFFFF -> wraps to 0.
- Async reset: drop rst mid-scan and mid-debounce, between clock edges -> all outputs 0 immediately; after release, a full 7-cycle debounce is needed again.
